// File: rtl/cv32e40p_tmr_fault_manager.sv
// Fault manager for the cv32e40p triple-replica voter: leaky-bucket error counters,
// replica retirement into two-input mode, and a req/ack recovery handshake with sticky failure.
module cv32e40p_tmr_fault_manager #(
   parameter int unsigned THRESH       = 4,
   parameter int unsigned DECAY_PERIOD = 8,
   parameter int unsigned MAX_RETRY    = 2,
   parameter int unsigned CNT_W        = $clog2(THRESH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               vote_valid_i,
   input  logic               err_detected_1_i,
   input  logic               err_detected_2_i,
   input  logic               err_detected_3_i,
   input  logic               err_corrected_i,
   input  logic               recovery_ack_i,
   output logic               only_two_o,
   output logic [1:0]         sel_a_o,
   output logic [1:0]         sel_b_o,
   output logic [2:0]         faulty_o,
   output logic [3*CNT_W-1:0] err_cnt_o,
   output logic               recovery_req_o,
   output logic               fail_o,
   output logic [1:0]         state_o
);

   localparam int unsigned CLEAN_W  = (DECAY_PERIOD > 0) ? $clog2(DECAY_PERIOD + 1) : 1;
   localparam int unsigned RETRY_W  = $clog2(MAX_RETRY + 1);
   localparam bit          DECAY_EN = (DECAY_PERIOD > 0);

   typedef enum logic [1:0] {
      ST_TMR      = 2'b00,
      ST_DMR      = 2'b01,
      ST_RECOVERY = 2'b10,
      ST_FAIL     = 2'b11
   } state_e;

   state_e               state_q, state_d;
   state_e               ret_state_q, ret_state_d;
   logic                 only_two_q, only_two_d;
   logic [1:0]           sel_a_q, sel_a_d;
   logic [1:0]           sel_b_q, sel_b_d;
   logic [2:0]           faulty_q, faulty_d;
   logic [CNT_W-1:0]     cnt_q [3];
   logic [CNT_W-1:0]     cnt_d [3];
   logic [CLEAN_W-1:0]   clean_cnt_q, clean_cnt_d;
   logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
   logic                 req_q, req_d;
   logic                 fail_q, fail_d;

   logic [2:0]           flags;
   logic                 single_flag;
   logic [1:0]           err_idx;
   logic [CNT_W-1:0]     cnt_inc;
   logic [CLEAN_W-1:0]   clean_inc;
   logic [RETRY_W-1:0]   retry_inc;
   logic                 recover;
   state_e               recover_from;

   assign flags     = {err_detected_3_i, err_detected_2_i, err_detected_1_i};
   assign clean_inc = clean_cnt_q + CLEAN_W'(1);
   assign retry_inc = retry_cnt_q + RETRY_W'(1);
   assign cnt_inc   = cnt_q[err_idx] + CNT_W'(1);

   always_comb begin
      single_flag = 1'b1;
      err_idx     = 2'd0;
      case (flags)
         3'b001:  err_idx = 2'd0;
         3'b010:  err_idx = 2'd1;
         3'b100:  err_idx = 2'd2;
         default: single_flag = 1'b0;
      endcase
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      ret_state_d  = ret_state_q;
      only_two_d   = only_two_q;
      sel_a_d      = sel_a_q;
      sel_b_d      = sel_b_q;
      faulty_d     = faulty_q;
      cnt_d        = cnt_q;
      clean_cnt_d  = clean_cnt_q;
      retry_cnt_d  = retry_cnt_q;
      req_d        = req_q;
      fail_d       = fail_q;
      recover      = 1'b0;
      recover_from = ST_TMR;

      case (state_q)
         ST_TMR: begin
            if (vote_valid_i) begin
               if (flags == 3'b000) begin
                  retry_cnt_d = '0;
                  if (DECAY_EN && (clean_inc == CLEAN_W'(DECAY_PERIOD))) begin
                     clean_cnt_d = '0;
                     for (int i = 0; i < 3; i++) begin
                        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
                     end
                  end else begin
                     clean_cnt_d = clean_inc;
                  end
               end else if (single_flag && err_corrected_i) begin
                  clean_cnt_d = '0;
                  if (cnt_q[err_idx] < CNT_W'(THRESH)) cnt_d[err_idx] = cnt_inc;
                  if (cnt_inc == CNT_W'(THRESH)) begin
                     faulty_d[err_idx] = 1'b1;
                     state_d           = ST_DMR;
                     only_two_d        = 1'b1;
                     // Survivors in ascending order onto voter inputs 1/2.
                     case (err_idx)
                        2'd0:    begin sel_a_d = 2'd1; sel_b_d = 2'd2; end
                        2'd1:    begin sel_a_d = 2'd0; sel_b_d = 2'd2; end
                        default: begin sel_a_d = 2'd0; sel_b_d = 2'd1; end
                     endcase
                  end
               end else begin
                  recover      = 1'b1;
                  recover_from = ST_TMR;
               end
            end
         end
         ST_DMR: begin
            if (vote_valid_i) begin
               if (err_detected_1_i) begin
                  recover      = 1'b1;
                  recover_from = ST_DMR;
               end else if (flags == 3'b000) begin
                  retry_cnt_d = '0;
               end
            end
         end
         ST_RECOVERY: begin
            if (recovery_ack_i) begin
               req_d   = 1'b0;
               state_d = ret_state_q;
            end
         end
         default: ;
      endcase

      if (recover) begin
         ret_state_d = recover_from;
         retry_cnt_d = retry_inc;
         if (retry_inc == RETRY_W'(MAX_RETRY)) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            req_d   = 1'b0;
         end else begin
            state_d = ST_RECOVERY;
            req_d   = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the counter array is small
   // and fully reset so every output has a defined value straight out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_TMR;
         ret_state_q <= ST_TMR;
         only_two_q  <= 1'b0;
         sel_a_q     <= 2'd0;
         sel_b_q     <= 2'd1;
         faulty_q    <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
         clean_cnt_q <= '0;
         retry_cnt_q <= '0;
         req_q       <= 1'b0;
         fail_q      <= 1'b0;
      end else if (clear_i) begin
         state_q     <= ST_TMR;
         ret_state_q <= ST_TMR;
         only_two_q  <= 1'b0;
         sel_a_q     <= 2'd0;
         sel_b_q     <= 2'd1;
         faulty_q    <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
         clean_cnt_q <= '0;
         retry_cnt_q <= '0;
         req_q       <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_state_q <= ret_state_d;
         only_two_q  <= only_two_d;
         sel_a_q     <= sel_a_d;
         sel_b_q     <= sel_b_d;
         faulty_q    <= faulty_d;
         cnt_q       <= cnt_d;
         clean_cnt_q <= clean_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         req_q       <= req_d;
         fail_q      <= fail_d;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_cnt_pack
      assign err_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
   end

   assign only_two_o     = only_two_q;
   assign sel_a_o        = sel_a_q;
   assign sel_b_o        = sel_b_q;
   assign faulty_o       = faulty_q;
   assign recovery_req_o = req_q;
   assign fail_o         = fail_q;
   assign state_o        = state_q;

endmodule

// File: doc/cv32e40p_tmr_fault_manager.md
Name: cv32e40p_tmr_fault_manager

Overview:
- Sequential controller for the triple-replica majority voter in the fault-tolerant cv32e40p.
- Consumes per-cycle voter error flags and keeps a leaky-bucket error count per replica.
- Retires a replica that crosses a threshold, then steers the voter into two-input mode and routes the surviving replicas onto voter inputs 1/2.
- On uncorrectable disagreement, requests a pipeline recovery through a req/ack handshake; declares sticky failure after too many consecutive recoveries.

Parameters:
- THRESH, 4, per-replica error count that retires a replica (>=1).
- DECAY_PERIOD, 8, consecutive clean TMR votes per counter decrement; 0 disables decay.
- MAX_RETRY, 2, consecutive recoveries without an intervening clean vote before FAIL (>=1).
- CNT_W, $clog2(THRESH+1), counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous active-low
- clear_i  in  1  synchronous clear of all state to reset values
- vote_valid_i  in  1  voter flags valid this cycle
- err_detected_1_i / err_detected_2_i / err_detected_3_i  in  1 each  voter per-input disagreement flags
- err_corrected_i  in  1  voter corrected flag
- recovery_ack_i  in  1  recovery done (from controller/pipeline flush)
- only_two_o  out  1  drives voter only_two_i
- sel_a_o  out  2  replica index (0..2) routed to voter input 1
- sel_b_o  out  2  replica index routed to voter input 2
- faulty_o  out  3  sticky retired-replica mask
- err_cnt_o  out  3*CNT_W  packed per-replica counters, replica 0 in LSBs
- recovery_req_o  out  1  recovery request
- fail_o  out  1  sticky unrecoverable failure
- state_o  out  2  FSM state: 00 TMR, 01 DMR, 10 RECOVERY, 11 FAIL

Behaviour:
- All outputs registered. Flags sampled at edge N appear in outputs after edge N (1-cycle latency).
- Reset (async) and clear_i (sync, highest priority) values: state TMR, only_two_o 0, sel_a_o 0, sel_b_o 1, faulty_o 000, err_cnt_o 0, recovery_req_o 0, fail_o 0. Internal retry_cnt, clean_cnt and ret_state also return to their reset values.
- TMR, vote_valid_i=1:
  - Exactly one flag j set with err_corrected_i=1: cnt[j] saturating-increments and clean_cnt clears.
  - If the incremented cnt[j]==THRESH: faulty_o[j]<=1, state<=DMR, only_two_o<=1, sel_a_o/sel_b_o <= the two remaining indices in ascending order.
  - Any other nonzero flag pattern is uncorrectable: state<=RECOVERY, ret_state<=TMR, retry_cnt++. Counters are unchanged.
  - All flags 0 (clean): retry_cnt<=0, clean_cnt++.
  - When clean_cnt reaches DECAY_PERIOD (nonzero), every nonzero cnt decrements by 1 and clean_cnt<=0.
- DMR: flags are relative to the sel mapping.
  - vote_valid_i & err_detected_1_i: state<=RECOVERY, ret_state<=DMR, retry_cnt++.
  - Clean vote: retry_cnt<=0.
  - Counters frozen; no decay; no further retirement.
- Entry into RECOVERY:
  - If the new retry_cnt==MAX_RETRY, go directly to FAIL instead (recovery_req_o stays 0).
  - Otherwise recovery_req_o<=1, held until recovery_ack_i is sampled high. Then recovery_req_o<=0 and state<=ret_state in the same edge.
  - ack is ignored outside RECOVERY.
- RECOVERY and FAIL ignore vote_valid_i and all flags.
- FAIL: fail_o=1 and recovery_req_o=0. Other outputs hold. Exits only via reset or clear_i.
- vote_valid_i=0 leaves all state unchanged, including clean_cnt.
- Counter at THRESH never wraps.
- sel_a_o != sel_b_o always. In TMR, sel_a_o=0 and sel_b_o=1.

Test Plan:
- Reset, then 10 clean valid votes -> state 00, err_cnt_o 0, only_two_o 0, sel 0/1.
- 4 votes flag2-only with corrected=1 -> after 4th edge: faulty_o=010, state 01, only_two_o 1, sel_a 0, sel_b 2, cnt[1]=4.
- flag1-only twice, then 8 clean votes -> cnt[0] goes 2 then 1; a further 8 clean votes -> 0, never negative.
- All three flags, corrected=0 in TMR -> recovery_req_o=1 next cycle and held 5 cycles without ack. ack pulse -> req drops and state 00 on the same edge.
- From DMR: mismatch, ack, mismatch with no clean vote between (MAX_RETRY=2) -> second mismatch goes to state 11 and fail_o=1. vote/ack then ignored; clear_i -> all reset values.
- Async rst_ni low mid-RECOVERY with req=1 -> req 0, state 00 immediately, without waiting for a clock edge.
